ne_bitserial: RTL and testbench

//   Bit-serial counterpart of the parallel n-bit NE submodule for the PIM datapath.

---
 rtl/ne_bitserial.sv | 91 +++++++++
 tb/tb_ne_bitserial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ne_bitserial.sv
// Bit-serial not-equal comparator. Operand bit pairs stream in LSB first;
// the block reports NE/EQ and the index of the lowest differing bit, and
// holds that result until the next start.
module ne_bitserial #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             ne,
  output logic             eq,
  output logic [IDX_W-1:0] first_diff_idx
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_acc;
  logic             ne_acc;

  // A pair is taken only in SHIFT and never in a cycle where start wins.
  logic accept, last, d, first_hit;
  assign accept    = (state == SHIFT) && bit_valid && !start;
  assign last      = (cnt == IDX_W'(WIDTH - 1));
  assign d         = a_bit ^ b_bit;
  assign first_hit = d && !ne_acc;

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    bit_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        bit_ready = 1'b1;
        if (start)                state_nxt = SHIFT;
        else if (accept && last)  state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulators and the held result; the result registers load together
  // with the final pair so they are valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt            <= '0;
      ne_acc         <= 1'b0;
      idx_acc        <= '0;
      result_valid   <= 1'b0;
      ne             <= 1'b0;
      eq             <= 1'b0;
      first_diff_idx <= '0;
    end else if (accept) begin
      cnt    <= cnt + IDX_W'(1);
      ne_acc <= ne_acc | d;
      if (first_hit) idx_acc <= cnt;
      if (last) begin
        result_valid   <= 1'b1;
        ne             <= ne_acc | d;
        eq             <= ~(ne_acc | d);
        first_diff_idx <= first_hit ? cnt : idx_acc;
      end
    end
  end

endmodule

// File: tb/tb_ne_bitserial.sv
// Self-checking bench for ne_bitserial (WIDTH=8): directed scenarios plus
// randomized operands and stalls, checked against whole-word expectations.
module tb_ne_bitserial;
  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst, start, bit_valid, a_bit, b_bit;
  logic          bit_ready, busy, done, result_valid, ne, eq;
  logic [IW-1:0] first_diff_idx;

  int tests = 0;
  int fails = 0;

  ne_bitserial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .a_bit(a_bit), .b_bit(b_bit), .busy(busy),
    .done(done), .result_valid(result_valid), .ne(ne), .eq(eq),
    .first_diff_idx(first_diff_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Lowest set bit of a^b, 0 when the words are equal.
  function automatic logic [IW-1:0] ref_idx(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    int r;
    x = a ^ b;
    r = 0;
    for (int i = W - 1; i >= 0; i--) if (x[i]) r = i;
    return IW'(r);
  endfunction

  task automatic do_start();
    start = 1'b1; bit_valid = 1'b0;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rv", result_valid, 0);
    chk("start_ne", ne, 0);
  endtask

  // Feed bits [first, first+n) with an optional fixed stall before bit
  // stall_at and optional random stalls; junk bits are driven while stalled.
  task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input int first,
                      input int n, input int stall_at, input int stall_len, input bit rnd);
    for (int i = first; i < first + n; i++) begin
      int s;
      s = (i == stall_at) ? stall_len : 0;
      if (rnd && $urandom_range(3) == 0) s += int'($urandom_range(3, 1));
      repeat (s) begin
        bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
        cyc();
        chk("stall_busy", busy, 1);
        chk("stall_done", done, 0);
      end
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      cyc();
      bit_valid = 1'b0;
      if (i != W - 1) begin
        chk("shift_busy", busy, 1);
        chk("shift_done", done, 0);
      end
    end
  endtask

  task automatic check_res(input logic [W-1:0] a, input logic [W-1:0] b);
    chk("res_done", done, 1);
    chk("res_busy", busy, 0);
    chk("res_ready", bit_ready, 0);
    chk("res_rv", result_valid, 1);
    chk("res_ne", ne, a != b);
    chk("res_eq", eq, a == b);
    chk("res_idx", first_diff_idx, ref_idx(a, b));
  endtask

  task automatic check_held(input logic [W-1:0] a, input logic [W-1:0] b);
    chk("hold_done", done, 0);
    chk("hold_busy", busy, 0);
    chk("hold_rv", result_valid, 1);
    chk("hold_ne", ne, a != b);
    chk("hold_eq", eq, a == b);
    chk("hold_idx", first_diff_idx, ref_idx(a, b));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_ne"}, ne, 0);
    chk({tag, "_eq"}, eq, 0);
    chk({tag, "_idx"}, first_diff_idx, 0);
    chk({tag, "_ready"}, bit_ready, 0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
    do_start();
    feed(a, b, 0, W, -1, 0, rnd);
    check_res(a, b);
    cyc();
    check_held(a, b);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    cyc(); cyc();
    check_zero("reset");
    rst = 1'b0;

    // Equal operands, no stalls: done on the 9th edge after start.
    op(8'hA5, 8'hA5, 1'b0);

    // Mismatch at bit 0, then only at the last bit.
    op(8'hA5, 8'hA4, 1'b0);
    op(8'h80, 8'h00, 1'b0);

    // Three-cycle stall after bit 2; no pair is consumed while stalled.
    do_start();
    feed(8'h0F, 8'hF0, 0, W, 3, 3, 1'b0);
    check_res(8'h0F, 8'hF0);
    cyc();
    check_held(8'h0F, 8'hF0);

    // Restart after 5 mismatching bits, with a pair offered alongside start.
    do_start();
    feed(8'h00, 8'hFF, 0, 5, -1, 0, 1'b0);
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    cyc();
    start = 1'b0; bit_valid = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_rv", result_valid, 0);
    feed(8'h3C, 8'h3C, 0, W, -1, 0, 1'b0);
    check_res(8'h3C, 8'h3C);
    cyc();

    // Reset mid-SHIFT at bit 4, then pairs offered while idle are ignored.
    do_start();
    feed(8'hFF, 8'h00, 0, 4, -1, 0, 1'b0);
    rst = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    cyc();
    rst = 1'b0;
    check_zero("midrst");
    repeat (10) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      cyc();
      chk("idle_ready", bit_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rv", result_valid, 0);
    end
    bit_valid = 1'b0;
    op(8'h01, 8'h03, 1'b0);

    // Back-to-back: start in the DONE cycle.
    do_start();
    feed(8'h40, 8'h00, 0, W, -1, 0, 1'b0);
    check_res(8'h40, 8'h00);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("b2b_rv", result_valid, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    feed(8'h5A, 8'h5A, 0, W, -1, 0, 1'b0);
    check_res(8'h5A, 8'h5A);
    // Result held for 20 idle cycles while junk pairs are offered.
    repeat (20) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      cyc();
      check_held(8'h5A, 8'h5A);
      chk("hold_ready", bit_ready, 0);
    end
    bit_valid = 1'b0;
    op(8'h77, 8'h76, 1'b0);

    // Randomized operands and stalls.
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      case ($urandom_range(2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(W - 1));
        default: rb = W'($urandom);
      endcase
      op(ra, rb, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
